// File: rtl/not_32.sv
// 32-bit bitwise inverter: combinational ~in plus a registered copy with a valid flag.
// The datapath is split into VEC_W-bit lanes; WIDTH must be a multiple of VEC_W.

module not_32_lane #(
    parameter int VEC_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [VEC_W-1:0] lane_i,
    output logic [VEC_W-1:0] lane_o,
    output logic [VEC_W-1:0] lane_q_o
);
    logic [VEC_W-1:0] data_q, data_d;

    // Plain complement so X/Z on an input bit shows up as X on that output bit.
    assign lane_o = ~lane_i;

    always_comb begin
        data_d = data_q;
        if (en) data_d = lane_o;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign lane_q_o = data_q;
endmodule

module not_32 #(
    parameter int WIDTH = 32,
    parameter int VEC_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
);
    localparam int NUM_LANES = WIDTH / VEC_W;

    logic [NUM_LANES-1:0][VEC_W-1:0] in_lanes, out_lanes, outq_lanes;
    logic valid_q, valid_d;

    assign in_lanes = in;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        not_32_lane #(.VEC_W(VEC_W)) u_lane (
            .clock    (clock),
            .reset    (reset),
            .en       (en),
            .lane_i   (in_lanes[g]),
            .lane_o   (out_lanes[g]),
            .lane_q_o (outq_lanes[g])
        );
    end

    // Valid is sticky once anything has been captured since reset.
    always_comb begin
        valid_d = valid_q | en;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
    end

    assign out       = out_lanes;
    assign out_q     = outq_lanes;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_not_32.sv
// Scoreboarded bench for not_32: stimulus pushes expected results, monitors pop and compare.

module tb_not_32;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clock, reset, en;
    logic [31:0] in, out, out_q;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] comb_sb[$];
    logic [32:0] reg_sb[$];   // {valid, data}
    event        comb_ev, reg_ev;

    logic [31:0] exp_d;
    logic        exp_v;

    not_32 dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .en        (en),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: inversion as subtraction from all-ones.
    function automatic logic [31:0] inv_ref(input logic [31:0] v);
        return ONES - v;
    endfunction

    task automatic drive(input logic [31:0] v);
        in = v;
        comb_sb.push_back(inv_ref(v));
        -> comb_ev;
        #10;
    endtask

    task automatic push_reg();
        reg_sb.push_back({exp_v, exp_d});
        -> reg_ev;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset && en) begin
            exp_d = inv_ref(in);
            exp_v = 1'b1;
        end
        push_reg();
    endtask

    initial begin : comb_monitor
        logic [31:0] e;
        forever begin
            @(comb_ev);
            #1;
            e = comb_sb.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL comb out: in=%h got=%h exp=%h", in, out, e);
            end
            n_checks++;
            if ((ONES - out) !== in) begin
                n_fail++;
                $display("FAIL double_inv: in=%h got=%h", in, ONES - out);
            end
        end
    end

    initial begin : reg_monitor
        logic [32:0] e;
        forever begin
            @(reg_ev);
            #1;
            e = reg_sb.pop_front();
            n_checks++;
            if ({out_valid, out_q} !== e) begin
                n_fail++;
                $display("FAIL reg path: got valid=%b q=%h exp valid=%b q=%h",
                         out_valid, out_q, e[32], e[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        in    = '0;
        exp_d = '0;
        exp_v = 1'b0;

        @(negedge clock);
        push_reg();                    // reset state
        #2;
        reset = 1'b0;

        drive(32'h0000_0000);
        drive(32'hFFFF_FFFF);
        drive(32'hA5A5_A5A5);
        drive(32'h1234_5678);
        for (int i = 0; i < 24; i++) drive($urandom);

        @(negedge clock);
        push_reg();                    // en=0 throughout: still cleared

        @(negedge clock);
        en = 1'b1;
        in = 32'h0F0F_0F0F;
        tick();                        // expect F0F0F0F0, valid
        @(negedge clock);
        en = 1'b0;
        in = 32'hDEAD_BEEF;
        tick();                        // holds

        @(negedge clock);
        #2;
        reset = 1'b1;
        exp_d = '0;
        exp_v = 1'b0;
        push_reg();                    // async clear, mid-cycle
        @(negedge clock);
        en = 1'b1;
        in = 32'h1234_0000;
        tick();                        // held in reset despite en

        @(negedge clock);
        #1;
        reset = 1'b0;
        en    = 1'b1;
        in    = 32'h0000_0000;
        tick();                        // FFFFFFFF, valid

        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            en = 1'($urandom_range(0, 1));
            in = $urandom;
            tick();
        end

        #20;
        n_checks++;
        if (comb_sb.size() != 0 || reg_sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: comb left=%0d reg left=%0d exp 0", comb_sb.size(), reg_sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
